// File: rtl/hilo_mdu_if.sv
// Issue, MTHI/MTLO and readback signals of the HI/LO multiply-divide unit.
// master drives operations and register writes; slave is the unit itself.
interface hilo_mdu_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic              write_hi;
  logic              write_lo;
  logic [DATA_W-1:0] hi_data_in;
  logic [DATA_W-1:0] lo_data_in;
  logic              read_hi;
  logic [DATA_W-1:0] hilo_data_out;
  logic              busy;
  logic              done;

  modport master (
    output start, op, src_a, src_b, flush,
    output write_hi, write_lo, hi_data_in, lo_data_in, read_hi,
    input  hilo_data_out, busy, done
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    input  write_hi, write_lo, hi_data_in, lo_data_in, read_hi,
    output hilo_data_out, busy, done
  );
endinterface

// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: multiply result lands 2 cycles after start, divide DATA_W+2.
// No backpressure: start is dropped while busy; flush aborts without touching HI/LO.
module hilo_mdu #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic       clock,
  input logic       reset,
  hilo_mdu_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // op[0]=0 selects the signed flavour for both MULT and DIV
  logic w_a_neg;
  logic w_b_neg;
  assign w_a_neg = ~r_op[0] & r_a[DATA_W-1];
  assign w_b_neg = ~r_op[0] & r_b[DATA_W-1];

  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  assign w_a_mag = w_a_neg ? -r_a : r_a;
  assign w_b_mag = w_b_neg ? -r_b : r_b;

  // Extending to 2*DATA_W makes one multiplier serve both signed and unsigned
  logic [2*DATA_W-1:0] w_mul_a;
  logic [2*DATA_W-1:0] w_mul_b;
  logic [2*DATA_W-1:0] w_prod;
  assign w_mul_a = {{DATA_W{w_a_neg}}, r_a};
  assign w_mul_b = {{DATA_W{w_b_neg}}, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  logic [DATA_W:0]   w_shift;
  logic              w_ge;
  logic [DATA_W-1:0] w_sub;
  assign w_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_ge    = w_shift >= {1'b0, w_b_mag};
  // When the subtract succeeds the difference is below |b|, so DATA_W bits suffice
  assign w_sub   = w_shift[DATA_W-1:0] - w_b_mag;

  logic [DATA_W-1:0] w_res_hi;
  logic [DATA_W-1:0] w_res_lo;
  always_comb begin
    w_res_hi = r_rem;
    w_res_lo = r_quo;
    if (r_op[1]) begin
      if (r_b == '0) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_a_neg ? -r_rem : r_rem;
        w_res_lo = (w_a_neg ^ w_b_neg) ? -r_quo : r_quo;
      end
    end
  end

  logic w_commit;
  assign w_commit = (r_state == S_DONE) && !bus.flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_a     <= bus.src_a;
            r_b     <= bus.src_b;
            r_cnt   <= '0;
            r_state <= bus.op[1] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          {r_rem, r_quo} <= w_prod;
          r_state        <= S_DONE;
        end
        S_DIV: begin
          // First DIV cycle loads the magnitudes, the next DATA_W cycles each retire a quotient bit
          if (r_cnt == '0) begin
            r_rem <= '0;
            r_quo <= w_a_mag;
          end else begin
            r_rem <= w_ge ? w_sub : w_shift[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], w_ge};
          end
          if (r_cnt == LAST_CNT) begin
            r_state <= S_DONE;
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if (bus.flush) begin
        r_state <= S_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (bus.write_hi) begin
        r_hi <= bus.hi_data_in;
      end else if (w_commit) begin
        r_hi <= w_res_hi;
      end
      if (bus.write_lo) begin
        r_lo <= bus.lo_data_in;
      end else if (w_commit) begin
        r_lo <= w_res_lo;
      end
    end
  end

  assign bus.busy          = !reset && (r_state != S_IDLE);
  assign bus.done          = !reset && w_commit;
  assign bus.hilo_data_out = reset ? '0 : (bus.read_hi ? r_hi : r_lo);

endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: arithmetic reference model checked every cycle plus directed literal vectors.
module tb_hilo_mdu;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hilo_mdu_if #(.DATA_W(W)) bus ();

  hilo_mdu #(.DATA_W(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference result {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] golden(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (op)
      2'd0: begin
        q = sa * sb;
        p = q;
      end
      2'd1: p = {32'h0, a} * {32'h0, b};
      2'd2: begin
        if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Model: HI/LO contents plus cycles left until the result lands (1 = the done cycle)
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [63:0]  m_pend = '0;
  int           m_left = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else begin
      if (bus.write_hi) m_hi <= bus.hi_data_in;
      else if (m_left == 1 && !bus.flush) m_hi <= m_pend[63:32];
      if (bus.write_lo) m_lo <= bus.lo_data_in;
      else if (m_left == 1 && !bus.flush) m_lo <= m_pend[31:0];
      if (bus.flush) m_left <= 0;
      else if (m_left > 0) m_left <= m_left - 1;
      else if (bus.start) begin
        m_left <= bus.op[1] ? W + 2 : 2;
        m_pend <= golden(bus.op, bus.src_a, bus.src_b);
      end
    end
  end

  always @(negedge clock) begin
    check("busy", 64'(bus.busy), 64'(!reset && m_left > 0));
    check("done", 64'(bus.done), 64'(!reset && m_left == 1 && !bus.flush));
    check("hilo_data_out", 64'(bus.hilo_data_out), 64'(reset ? '0 : (bus.read_hi ? m_hi : m_lo)));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic read_pair(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.read_hi = 1'b1;
    #1 check({name, "_hi"}, 64'(bus.hilo_data_out), 64'(exp_hi));
    bus.read_hi = 1'b0;
    #1 check({name, "_lo"}, 64'(bus.hilo_data_out), 64'(exp_lo));
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int  k;
    bit  seen;
    issue(op, a, b);
    k = 1;
    seen = 1'b0;
    while (!seen && k <= 200) begin
      @(negedge clock);
      if (bus.done) seen = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    if (!seen) check({name, "_done_timeout"}, 64'(0), 64'(1));
    else check({name, "_latency"}, 64'(k), 64'(exp_lat));
    tick();
    read_pair(name, exp_hi, exp_lo);
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.op         = 2'd0;
    bus.src_a      = '0;
    bus.src_b      = '0;
    bus.flush      = 1'b0;
    bus.write_hi   = 1'b0;
    bus.write_lo   = 1'b0;
    bus.hi_data_in = '0;
    bus.lo_data_in = '0;
    bus.read_hi    = 1'b0;
    tick();
    tick();
    check("reset_out", 64'(bus.hilo_data_out), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    reset = 1'b0;
    tick();

    bus.write_hi   = 1'b1;
    bus.hi_data_in = 32'hAAAA_0000;
    bus.write_lo   = 1'b1;
    bus.lo_data_in = 32'h0000_5555;
    tick();
    bus.write_hi = 1'b0;
    bus.write_lo = 1'b0;
    read_pair("mthi_mtlo", 32'hAAAA_0000, 32'h0000_5555);

    run_op("mult",     2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 2,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",    2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",      2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000);
    run_op("divu",     2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 34, 32'h0000_000F, 32'h0FFF_FFFF);
    run_op("div_negb", 2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_zero", 2'd2, 32'hFFFF_FFFB, 32'h0000_0000, 34, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divu_zero", 2'd3, 32'h0000_0005, 32'h0000_0000, 34, 32'h0000_0005, 32'hFFFF_FFFF);

    // DIVU 100/7 flushed in cycle 10; a start in cycle 3 must be ignored
    issue(2'd3, 32'd100, 32'd7);
    tick();
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.src_a = 32'd9;
    bus.src_b = 32'd9;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_idle", 64'(bus.busy), 64'(0));
    read_pair("flush_keep", 32'h0000_0005, 32'hFFFF_FFFF);

    // New MULTU 2*3 right after the flush, with MTLO colliding with its done cycle
    issue(2'd1, 32'd2, 32'd3);
    tick();
    check("done_pulse", 64'(bus.done), 64'(1));
    bus.write_lo   = 1'b1;
    bus.lo_data_in = 32'h0000_1234;
    tick();
    bus.write_lo = 1'b0;
    read_pair("mtlo_wins", 32'h0000_0000, 32'h0000_1234);

    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.src_a = 32'd3;
    bus.src_b = 32'd3;
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_start_drop", 64'(bus.busy), 64'(0));

    // Reset mid-divide, with a competing MTHI that reset must override
    issue(2'd2, 32'd1000, 32'd3);
    repeat (5) tick();
    reset          = 1'b1;
    bus.write_hi   = 1'b1;
    bus.hi_data_in = 32'hDEAD_BEEF;
    #1 check("reset_gates_out", 64'(bus.hilo_data_out), 64'(0));
    tick();
    reset        = 1'b0;
    bus.write_hi = 1'b0;
    check("reset_mid_busy", 64'(bus.busy), 64'(0));
    read_pair("reset_mid", 32'h0000_0000, 32'h0000_0000);

    run_op("mult_neg", 2'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 32'h8000_0001);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the HI/LO register and operand width in bits (even, >=8).
REQ-002 The block SHALL have parameter CNT_W, default 6, giving the divide-counter width; it SHALL satisfy 2^CNT_W > DATA_W.
REQ-003 Port clock, input, 1: rising-edge clock for all state.
REQ-004 Port reset, input, 1: reset, synchronous, active-high.
REQ-005 Port start, input, 1: issue a multiply/divide when high for one cycle.
REQ-006 Port op, input, 2: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU; sampled with start.
REQ-007 Port src_a, input, DATA_W: dividend/multiplicand; sampled with start.
REQ-008 Port src_b, input, DATA_W: divisor/multiplier; sampled with start.
REQ-009 Port flush, input, 1: abort any in-flight operation.
REQ-010 Port write_hi and write_lo, input, 1 each: MTHI/MTLO write strobes.
REQ-011 Port hi_data_in and lo_data_in, input, DATA_W each: MTHI/MTLO data.
REQ-012 Port read_hi, input, 1: read-select; 1 selects HI, 0 selects LO.
REQ-013 Port hilo_data_out, output, DATA_W: selected register value.
REQ-014 Port busy, output, 1: an operation is in flight.
REQ-015 Port done, output, 1: one-cycle pulse in the cycle HI/LO receive a result.

Function
REQ-016 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-017 IDLE with start=1 and flush=0 SHALL go to MUL for op 0/1 and to DIV for op 2/3, latching op, src_a and src_b.
REQ-018 start while not IDLE SHALL be ignored, with no queuing.
REQ-019 MUL SHALL compute the full 2*DATA_W-bit product, signed for MULT and unsigned for MULTU.
REQ-020 MUL SHALL go to DONE after 1 cycle, so the result is written 2 cycles after start.
REQ-021 DIV SHALL perform restoring radix-2 division on the operand magnitudes, one quotient bit per cycle, for DATA_W cycles, then go to DONE.
REQ-022 Divide results SHALL be written DATA_W+2 cycles after start.
REQ-023 For DIV (signed), the quotient sign SHALL be sign(a) XOR sign(b), and the remainder sign SHALL equal sign(a).
REQ-024 Signed DIV of (most-negative)/(-1) SHALL give LO = most-negative and HI = 0.
REQ-025 Division by zero (src_b = 0) SHALL take the full DATA_W+2 cycles and give LO = all ones and HI = src_a, for both DIV and DIVU.
REQ-026 In DONE, for a multiply, HI SHALL take the upper half of the product and LO the lower half.
REQ-027 In DONE, for a divide, HI SHALL take the remainder and LO the quotient.
REQ-028 DONE SHALL assert done for one cycle and return to IDLE.
REQ-029 busy SHALL be 1 in MUL, DIV and DONE, and 0 in IDLE.
REQ-030 write_hi/write_lo SHALL update HI/LO at the next edge in any state.
REQ-031 If write_hi or write_lo coincides with DONE, the MTHI/MTLO data SHALL win for that register; the other register still takes the result.
REQ-032 flush SHALL return the FSM to IDLE at the next edge from any state, with no HI/LO result write and no done.
REQ-033 flush and start in the same cycle SHALL give flush priority; the start is dropped.
REQ-034 hilo_data_out SHALL be combinational: 0 while reset=1, else HI if read_hi=1, else LO.
REQ-035 hilo_data_out SHALL show registered values only, with no bypass of same-cycle writes.

Reset
REQ-036 reset=1 at an edge SHALL clear HI, LO, the divide datapath and the counter to 0, and put the FSM in IDLE.
REQ-037 While reset=1, busy, done and hilo_data_out SHALL all be 0.
REQ-038 reset SHALL take priority over start, flush and the MTHI/MTLO writes.
REQ-039 A reset asserted mid-divide SHALL abandon the operation; HI/LO are left at 0.

Verification
REQ-040 MULT, a=0xFFFFFFFE (-2), b=3 -> done 2 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-041 MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-042 DIV, a=-7, b=2 -> done at cycle 34 after start; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); busy=1 throughout.
REQ-043 DIV, a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU, a=5, b=0 -> LO=0xFFFFFFFF, HI=5.
REQ-044 DIVU 100/7 issued, flush at cycle 10 -> no done; HI/LO keep their prior values; a new start next cycle is accepted.
REQ-045 write_lo=1 with lo_data_in=0x1234 in the DONE cycle of MULTU 2*3 -> LO=0x1234 and HI=0. read_hi toggle -> hilo_data_out follows within the same cycle.
